// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD arithmetic path.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Controller state encoding, kept as plain constants for older tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A nibble is a legal BCD digit when it does not exceed nine.
  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single-digit BCD add/subtract with decimal carry or borrow.
module bcd_digit_addsub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic [DIGIT_W-1:0] digit,
  output logic               cout
);

  logic [5:0] sum_w;
  logic [5:0] diff_w;

  // Work in six bits so neither the add overflow nor the negative difference is truncated.
  always_comb begin
    sum_w  = {2'b00, a} + {2'b00, b} + {5'b00000, cin};
    diff_w = {2'b00, a} - {2'b00, b} - {5'b00000, cin};
    digit  = '0;
    cout   = 1'b0;
    if (sub) begin
      if (diff_w[5]) begin
        digit = 4'(diff_w + 6'd10);
        cout  = 1'b1;
      end else begin
        digit = 4'(diff_w);
      end
    end else begin
      if (sum_w > 6'd9) begin
        digit = 4'(sum_w - 6'd10);
        cout  = 1'b1;
      end else begin
        digit = 4'(sum_w);
      end
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial multi-digit BCD adder/subtractor, least significant digit first.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  sub_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   result_o,
  output logic                  carry_o,
  output logic                  invalid_o
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_sr_q, a_sr_d;
  logic [W-1:0]    b_sr_q, b_sr_d;
  logic [W-1:0]    res_sr_q, res_sr_d;
  logic [W+3:0]    res_cat;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic            bad_q, bad_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            inv_q, inv_d;
  logic            done_q, done_d;
  logic            accept;
  logic [3:0]      dig;
  logic            dig_cout;

  // The one digit slice, always fed from the bottom of the operand shift registers.
  bcd_digit_addsub u_digit (
    .a     (a_sr_q[3:0]),
    .b     (b_sr_q[3:0]),
    .cin   (carry_q),
    .sub   (sub_q),
    .digit (dig),
    .cout  (dig_cout)
  );

  // Next-state logic: capture on start, shift one digit per RUN cycle, publish from DONE.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    bad_d    = bad_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    res_cat  = {dig, res_sr_q} >> 4;

    case (state_q)
      ST_IDLE: begin
        accept = start_i;
      end
      ST_RUN: begin
        a_sr_d   = a_sr_q >> 4;
        b_sr_d   = b_sr_q >> 4;
        res_sr_d = res_cat[W-1:0];
        carry_d  = dig_cout;
        bad_d    = bad_q | ~digit_valid(a_sr_q[3:0]) | ~digit_valid(b_sr_q[3:0]);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        result_d = bad_q ? '0 : res_sr_q;
        cout_d   = bad_q ? 1'b0 : carry_q;
        inv_d    = bad_q;
        state_d  = ST_IDLE;
        accept   = start_i;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      a_sr_d  = a_i;
      b_sr_d  = b_i;
      sub_d   = sub_i;
      carry_d = 1'b0;
      bad_d   = 1'b0;
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign carry_o   = cout_q;
  assign invalid_o = inv_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Self-checking bench for bcd_addsub_seq with a decimal-integer reference model.
module tb_bcd_addsub_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = DIGITS + 1;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         sub_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         carry_o;
  logic         invalid_o;

  int checks = 0;
  int failures = 0;

  bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .sub_i     (sub_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .carry_o   (carry_o),
    .invalid_o (invalid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: decode to integers, do decimal arithmetic, re-encode.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic inv);
    int av, bv, rv, modv;
    logic [3:0] na, nb;
    av = 0; bv = 0; inv = 1'b0; modv = 1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na > 4'd9 || nb > 4'd9) inv = 1'b1;
      av = av * 10 + int'(na);
      bv = bv * 10 + int'(nb);
      modv = modv * 10;
    end
    if (s) begin
      c  = (av < bv);
      rv = c ? av - bv + modv : av - bv;
    end else begin
      rv = av + bv;
      c  = (rv >= modv);
      if (c) rv = rv - modv;
    end
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rv % 10);
      rv = rv / 10;
    end
    if (inv) begin
      r = '0;
      c = 1'b0;
    end
  endfunction

  // Present an operation for exactly one rising edge, then drop start.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk_i);
    a_i = a; b_i = b; sub_i = s; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Called 1 time unit after the start edge; counts edges until done_o is seen.
  task automatic wait_done(output int lat, output int busy_cnt, output bit timeout,
                           output logic [W-1:0] r, output logic c, output logic inv);
    lat = 0; timeout = 1'b0;
    busy_cnt = busy_o ? 1 : 0;
    forever begin
      @(posedge clk_i);
      #1;
      lat++;
      if (done_o === 1'b1) break;
      if (busy_o === 1'b1) busy_cnt++;
      if (lat > 40) begin
        timeout = 1'b1;
        break;
      end
    end
    r = result_o; c = carry_o; inv = invalid_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b1;
    a_i = 16'h1234; b_i = 16'h0001;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({busy_o, done_o, result_o, carry_o, invalid_o} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b res=%h c=%b inv=%b, want all zero",
               busy_o, done_o, result_o, carry_o, invalid_o);
    end
    start_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h4321, 16'h1234, 16'h0500, 16'h9999, 16'h0456, 16'h12A4};
    logic [W-1:0] tb [6] = '{16'h1234, 16'h4321, 16'h0500, 16'h0001, 16'h0789, 16'h0001};
    logic         ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] er [6] = '{16'h3087, 16'h6913, 16'h0000, 16'h0000, 16'h1245, 16'h0000};
    logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic         ei [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bc;
    bit to;
    logic [W-1:0] r;
    logic c, inv;
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb[i], ts[i]);
      wait_done(lat, bc, to, r, c, inv);
      checks++;
      if (to || lat != LAT || bc != DIGITS) begin
        failures++;
        $display("[TB] FAIL directed_latency[%0d]: got lat=%0d busy=%0d timeout=%0b, want lat=%0d busy=%0d",
                 i, lat, bc, to, LAT, DIGITS);
      end
      checks++;
      if (r !== er[i] || c !== ec[i] || inv !== ei[i]) begin
        failures++;
        $display("[TB] FAIL directed_result[%0d]: got res=%h c=%b inv=%b, want res=%h c=%b inv=%b",
                 i, r, c, inv, er[i], ec[i], ei[i]);
      end
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (done_o !== 1'b0 || result_o !== er[5] || invalid_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL result_hold: got done=%b res=%h inv=%b, want done=0 res=%h inv=1",
               done_o, result_o, invalid_o, er[5]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic s, c, inv, ec, ei;
    int lat, bc;
    bit to;
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < DIGITS; d++) begin
        a[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        b[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      s = 1'($urandom_range(0, 1));
      model(a, b, s, er, ec, ei);
      start_op(a, b, s);
      wait_done(lat, bc, to, r, c, inv);
      checks++;
      if (to || lat != LAT || r !== er || c !== ec || inv !== ei) begin
        failures++;
        $display("[TB] FAIL random[%0d] %h %s %h: got res=%h c=%b inv=%b lat=%0d, want res=%h c=%b inv=%b lat=%0d",
                 n, a, s ? "-" : "+", b, r, c, inv, lat, er, ec, ei, LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] r, er;
    logic c, inv, ec, ei;
    int lat, bc, extra;
    bit to;
    model(16'h5678, 16'h1111, 1'b0, er, ec, ei);
    start_op(16'h5678, 16'h1111, 1'b0);
    @(posedge clk_i);
    #1;
    a_i = 16'h0002; b_i = 16'h0003; sub_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    a_i = 16'h9999;
    wait_done(lat, bc, to, r, c, inv);
    checks++;
    if (to || lat != LAT - 2 || r !== er || c !== ec || inv !== ei) begin
      failures++;
      $display("[TB] FAIL ignore_start: got res=%h c=%b inv=%b lat=%0d, want res=%h c=%b inv=%b lat=%0d",
               r, c, inv, lat, er, ec, ei, LAT - 2);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk_i);
      #1;
      if (done_o === 1'b1 || busy_o === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("[TB] FAIL ignore_no_second_op: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, er1, er2, er3;
    logic c, inv, ec1, ei1, ec2, ei2, ec3, ei3;
    int lat, bc;
    bit to;
    model(16'h0815, 16'h0815, 1'b0, er1, ec1, ei1);
    model(16'h3000, 16'h0001, 1'b1, er2, ec2, ei2);
    model(16'h0042, 16'h0999, 1'b1, er3, ec3, ei3);
    start_op(16'h0815, 16'h0815, 1'b0);
    wait_done(lat, bc, to, r, c, inv);
    checks++;
    if (to || r !== er1 || c !== ec1) begin
      failures++;
      $display("[TB] FAIL b2b_first: got res=%h c=%b, want res=%h c=%b", r, c, er1, ec1);
    end
    // Start while done_o is high.
    a_i = 16'h3000; b_i = 16'h0001; sub_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_busy_next: got busy=%b, want 1", busy_o);
    end
    // Start in the cycle right after busy drops, before done_o appears.
    bc = 0;
    while (busy_o === 1'b1 && bc < 20) begin
      @(posedge clk_i);
      #1;
      bc++;
    end
    a_i = 16'h0042; b_i = 16'h0999; sub_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b1 || result_o !== er2 || carry_o !== ec2) begin
      failures++;
      $display("[TB] FAIL b2b_overlap: got busy=%b done=%b res=%h c=%b, want busy=1 done=1 res=%h c=%b",
               busy_o, done_o, result_o, carry_o, er2, ec2);
    end
    wait_done(lat, bc, to, r, c, inv);
    checks++;
    if (to || lat != LAT || r !== er3 || c !== ec3 || inv !== ei3) begin
      failures++;
      $display("[TB] FAIL b2b_third: got res=%h c=%b inv=%b lat=%0d, want res=%h c=%b inv=%b lat=%0d",
               r, c, inv, lat, er3, ec3, ei3, LAT);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r, er;
    logic c, inv, ec, ei;
    int lat, bc, seen;
    bit to;
    start_op(16'h2222, 16'h3333, 1'b0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0 || result_o !== 16'h0000 || done_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_op: got busy=%b res=%h done=%b, want 0 0000 0", busy_o, result_o, done_o);
    end
    rst_i = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk_i);
      #1;
      if (done_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("[TB] FAIL reset_no_done: got %0d done pulses, want 0", seen);
    end
    model(16'h0100, 16'h0250, 1'b1, er, ec, ei);
    start_op(16'h0100, 16'h0250, 1'b1);
    wait_done(lat, bc, to, r, c, inv);
    checks++;
    if (to || lat != LAT || r !== er || c !== ec || inv !== ei) begin
      failures++;
      $display("[TB] FAIL after_reset_op: got res=%h c=%b inv=%b lat=%0d, want res=%h c=%b inv=%b lat=%0d",
               r, c, inv, lat, er, ec, ei, LAT);
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
